// File: rtl/attention_score_drain_if.sv
// Drain-stage bus: upstream push/credit side plus the downstream valid/ready score port.
interface attention_score_drain_if #(
    parameter int ACC_W = 18,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
);
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic [ACC_W-1:0]  acc_in;
    logic              acc_vld_in;
    logic              credit_out;
    logic [OUT_W-1:0]  score_mst_out;
    logic              vld_mst_out;
    logic              rdy_mst_in;
    logic [FILL_W-1:0] fill_out;
    logic              ovf_err_out;

    modport master (
        input  acc_in, acc_vld_in, rdy_mst_in,
        output credit_out, score_mst_out, vld_mst_out, fill_out, ovf_err_out
    );

    modport slave (
        output acc_in, acc_vld_in, rdy_mst_in,
        input  credit_out, score_mst_out, vld_mst_out, fill_out, ovf_err_out
    );
endinterface

// File: rtl/attention_score_drain.sv
// Attention score drain: quantize MAC accumulator (shift + saturate) into a
// credit-managed FIFO that feeds a valid/ready master port.
module attention_score_drain #(
    parameter int ACC_W = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    attention_score_drain_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             credit_q, credit_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] q_sh;
    logic [OUT_W-1:0] q_sat;
    logic             pop, push, full;

    assign q_sh  = bus.acc_in >> SHIFT;
    assign q_sat = (q_sh > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : q_sh[OUT_W-1:0];

    assign full = (cnt_q == FULL_CNT);
    assign pop  = (cnt_q != '0) && bus.rdy_mst_in;
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign push = bus.acc_vld_in && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        credit_d = pop;
        ovf_d    = ovf_q | (bus.acc_vld_in && full && !pop);

        if (push) begin
            mem_d[wr_ptr_q] = q_sat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.score_mst_out = mem_q[rd_ptr_q];
    assign bus.vld_mst_out   = (cnt_q != '0);
    assign bus.fill_out      = cnt_q;
    assign bus.credit_out    = credit_q;
    assign bus.ovf_err_out   = ovf_q;
endmodule
